// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
// Provides the FSM state encoding and a constant clog2 for counter sizing.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_unit_digit_adder.sv
// Combinational DIGIT-bit ripple adder used once per serial step.
// Ports: a, b, cin in; sum, cout, c_msb_in (carry into the top bit) out.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    always_comb begin
        logic c;
        c        = cin;
        sum      = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb_in = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first.
// Ports: clk, reset, start, sub, op_a, op_b in; busy, dout, dout_valid,
// done, result, carry_out, overflow out.
module serial_addsub_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [DIGIT-1:0] dout,
    output logic             dout_valid,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    import serial_arith_pkg::*;

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_t state, state_nxt;

    logic [WIDTH-1:0]       a_sh, b_sh, res_sh;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [CW-1:0]          cnt;
    logic                   carry, ovf_q;
    logic [DIGIT-1:0]       s;
    logic                   c, c_msb;
    logic                   accept, run, last;

    digit_adder #(.DIGIT(DIGIT)) u_add (
        .a        (a_sh[DIGIT-1:0]),
        .b        (b_sh[DIGIT-1:0]),
        .cin      (carry),
        .sum      (s),
        .cout     (c),
        .c_msb_in (c_msb)
    );

    assign run     = (state == RUN);
    assign accept  = start && !run;
    assign last    = run && (cnt == LAST);
    // New digit enters at the MSB end; the concat avoids an empty slice
    // when DIGIT == WIDTH.
    assign res_cat = {s, res_sh};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = run;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            ovf_q      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_out  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done       <= (state == DONE);
            dout_valid <= run;
            dout       <= run ? s : '0;
            // Published flags come from the carry/overflow left by the
            // last digit; an accepted start in DONE overwrites carry
            // only after this read.
            if (state == DONE) begin
                result    <= res_sh;
                carry_out <= carry;
                overflow  <= ovf_q;
            end
            if (accept) begin
                a_sh  <= op_a;
                b_sh  <= sub ? ~op_b : op_b;
                carry <= sub;
                cnt   <= '0;
            end else if (run) begin
                a_sh   <= a_sh >> DIGIT;
                b_sh   <= b_sh >> DIGIT;
                carry  <= c;
                res_sh <= res_cat[WIDTH+DIGIT-1:DIGIT];
                cnt    <= cnt + 1'b1;
                if (last) begin
                    ovf_q <= c_msb ^ c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit: DIGIT=1 and DIGIT=4 instances.
// Expected values are hand-computed constants.
module tb_serial_addsub_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start, sub;
    logic [7:0] op_a, op_b;
    logic       busy, dout, dout_valid, done, carry_out, overflow;
    logic [7:0] result;

    logic       start4, sub4;
    logic [7:0] op_a4, op_b4;
    logic       busy4, dout_valid4, done4, carry_out4, overflow4;
    logic [3:0] dout4;
    logic [7:0] result4;

    int n_cmp = 0;
    int n_bad = 0;

    serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sub        (sub),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out),
        .overflow   (overflow)
    );

    serial_addsub_unit #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .start      (start4),
        .sub        (sub4),
        .op_a       (op_a4),
        .op_b       (op_b4),
        .busy       (busy4),
        .dout       (dout4),
        .dout_valid (dout_valid4),
        .done       (done4),
        .result     (result4),
        .carry_out  (carry_out4),
        .overflow   (overflow4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one DIGIT=1 operation; a stray start with other operands is
    // pulsed at cycle 'glitch' of the run when glitch > 0.
    task automatic op8(input string tag, input logic s_sub,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_r, input logic exp_c,
                       input logic exp_v, input int glitch);
        int lat;
        int dcnt;
        logic [7:0] dig;
        sub   = s_sub;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat  = 0;
        dcnt = 0;
        dig  = '0;
        while (!done && lat < 20) begin
            if (glitch > 0 && lat == glitch) begin
                start = 1'b1;
                sub   = 1'b0;
                op_a  = 8'h01;
                op_b  = 8'h01;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
            if (dout_valid) begin
                if (dcnt < 8) dig[dcnt] = dout;
                dcnt++;
            end
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'd9);
        chk({tag, "_res"}, 32'(result), 32'(exp_r));
        chk({tag, "_cout"}, 32'(carry_out), 32'(exp_c));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_v));
        chk({tag, "_ndig"}, 32'(dcnt), 32'd8);
        chk({tag, "_digits"}, 32'(dig), 32'(exp_r));
        tick();
        chk({tag, "_done1cyc"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(result), 32'(exp_r));
    endtask

    initial begin
        int ndone;
        reset  = 1'b1;
        start  = 1'b0;
        sub    = 1'b0;
        op_a   = '0;
        op_b   = '0;
        start4 = 1'b0;
        sub4   = 1'b0;
        op_a4  = '0;
        op_b4  = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        chk("rst_dv", 32'(dout_valid), 32'd0);
        chk("rst_flags", 32'({carry_out, overflow}), 32'd0);
        chk("rst4_busy", 32'(busy4), 32'd0);
        reset = 1'b0;
        tick();

        op8("add3c55", 1'b0, 8'h3C, 8'h55, 8'h91, 1'b0, 1'b1, 0);
        op8("sub1020", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 0);
        op8("addff01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
        op8("ignore",  1'b0, 8'h3C, 8'h55, 8'h91, 1'b0, 1'b1, 3);

        // Abort mid-run with reset.
        sub   = 1'b0;
        op_a  = 8'h22;
        op_b  = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dout", 32'({dout, dout_valid}), 32'd0);
        chk("abort_res", 32'(result), 32'd0);
        chk("abort_flags", 32'({carry_out, overflow}), 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        op8("after_rst", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 0);

        // DIGIT=4: sub then back-to-back add accepted in DONE.
        sub4   = 1'b1;
        op_a4  = 8'h80;
        op_b4  = 8'h01;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("d4_busy", 32'(busy4), 32'd1);
        tick();
        chk("d4_dig0", 32'({dout_valid4, dout4}), 32'h1F);
        tick();
        chk("d4_nodone", 32'(done4), 32'd0);
        sub4   = 1'b0;
        op_a4  = 8'h12;
        op_b4  = 8'h34;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("d4_done", 32'(done4), 32'd1);
        chk("d4_res", 32'(result4), 32'h7F);
        chk("d4_flags", 32'({carry_out4, overflow4}), 32'h3);
        chk("d4_b2b_busy", 32'(busy4), 32'd1);
        tick();
        chk("d4_b2b_dig0", 32'(dout4), 32'h6);
        chk("d4_b2b_hold", 32'(result4), 32'h7F);
        tick();
        chk("d4_b2b_dig1", 32'(dout4), 32'h4);
        chk("d4_b2b_early", 32'(done4), 32'd0);
        tick();
        chk("d4_b2b_done", 32'(done4), 32'd1);
        chk("d4_b2b_res", 32'(result4), 32'h46);
        chk("d4_b2b_flags", 32'({carry_out4, overflow4}), 32'h0);
        tick();
        chk("d4_idle", 32'({busy4, done4}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
